spi_flash_responder: RTL and testbench

- Synthesizable SPI mode-0 responder that emulates a serial NOR flash for the CPU's program-memory SPI initiator.
- It answers READ (0x03) from a local byte-wide memory port and READ STATUS (0x05) with 0x00.
- It sits in the on-chip self-test path and in emulation builds, replacing the external flash on the uio SPI pins (cs, mosi, sck, miso).

---
 rtl/spi_flash_pkg.sv | 25 ++
 rtl/spi_flash_responder_if.sv | 49 ++++
 rtl/spi_sync_edge.sv | 43 ++++
 rtl/spi_flash_responder.sv | 255 +++++++++++++++++++++++++
 tb/tb_spi_flash_responder.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_flash_pkg.sv
// ----------------------------------------------------------------------------
// spi_flash_pkg
// Shared definitions for the SPI NOR-flash responder:
//   - responder state encoding
//   - the two supported opcodes
//   - the width of the address field carried on the SPI bus
// ----------------------------------------------------------------------------
package spi_flash_pkg;

  // Width of the address field that follows a READ opcode on the wire.
  localparam int ADDR_BITS_FLASH = 24;

  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_RDSR = 8'h05;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    ADDR   = 3'd2,
    STAT   = 3'd3,
    DATA   = 3'd4,
    IGNORE = 3'd5
  } state_t;

endpackage

// File: rtl/spi_flash_responder_if.sv
// ----------------------------------------------------------------------------
// spi_flash_responder_if
// Bundles the SPI pins and the byte-wide memory read port of the responder.
//   spi_cs, spi_sck, spi_mosi : SPI inputs from the initiator
//   spi_miso, spi_miso_oe     : SPI read data and its output enable
//   mem_rd_en, mem_addr       : one-cycle read strobe and byte address
//   mem_rdata                 : read data, valid one clk after mem_rd_en
// Modports:
//   slave  - the responder side
//   master - the environment (SPI initiator + memory) side
// ----------------------------------------------------------------------------
interface spi_flash_responder_if
  import spi_flash_pkg::*;
#(
  parameter int ADDR_W = 12
) ();

  logic              spi_cs;
  logic              spi_sck;
  logic              spi_mosi;
  logic              spi_miso;
  logic              spi_miso_oe;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;

  modport slave (
    input  spi_cs,
    input  spi_sck,
    input  spi_mosi,
    output spi_miso,
    output spi_miso_oe,
    output mem_rd_en,
    output mem_addr,
    input  mem_rdata
  );

  modport master (
    output spi_cs,
    output spi_sck,
    output spi_mosi,
    input  spi_miso,
    input  spi_miso_oe,
    input  mem_rd_en,
    input  mem_addr,
    output mem_rdata
  );

endinterface

// File: rtl/spi_sync_edge.sv
// ----------------------------------------------------------------------------
// spi_sync_edge
// Two-flop synchronizer for one asynchronous input, followed by a delay flop
// used to detect rising and falling edges of the synchronized level.
//   clk   : system clock
//   rst_n : synchronous active-low reset (all flops cleared)
//   din   : asynchronous input
//   sync  : synchronized level
//   rise  : one-cycle pulse when the synchronized level goes 0 -> 1
//   fall  : one-cycle pulse when the synchronized level goes 1 -> 0
// ----------------------------------------------------------------------------
module spi_sync_edge
  import spi_flash_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic meta_reg;
  logic sync_reg;
  logic prev_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
      prev_reg <= 1'b0;
    end else begin
      meta_reg <= din;
      sync_reg <= meta_reg;
      prev_reg <= sync_reg;
    end
  end

  assign sync = sync_reg;
  assign rise = sync_reg & ~prev_reg;
  assign fall = ~sync_reg & prev_reg;

endmodule

// File: rtl/spi_flash_responder.sv
// ----------------------------------------------------------------------------
// spi_flash_responder
// SPI mode-0 responder emulating a serial NOR flash. Supports READ (streams
// bytes from the local memory port, address auto-increments and wraps) and
// READ STATUS (returns 0x00 forever). Other opcodes are flagged with bad_cmd
// and the rest of the transaction is ignored.
// Ports:
//   clk     : system clock, all logic on the rising edge
//   rst_n   : synchronous active-low reset
//   bus     : SPI pins + memory read port (slave modport)
//   busy    : high while a transaction is open (state not IDLE)
//   bad_cmd : one-cycle pulse when an unsupported opcode completes
// ----------------------------------------------------------------------------
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter int         ADDR_W   = 12,
  parameter logic [7:0] CMD_READ = OP_READ,
  parameter logic [7:0] CMD_RDSR = OP_RDSR
) (
  input  logic                   clk,
  input  logic                   rst_n,
  spi_flash_responder_if.slave   bus,
  output logic                   busy,
  output logic                   bad_cmd
);

  // --------------------------------------------------------------------------
  // Input conditioning. Index 0 = sck, index 1 = cs.
  // --------------------------------------------------------------------------
  logic [1:0] raw_in;
  logic [1:0] edge_lvl;
  logic [1:0] edge_rise;
  logic [1:0] edge_fall;

  assign raw_in = {bus.spi_cs, bus.spi_sck};

  for (genvar gi = 0; gi < 2; gi++) begin : g_sync
    spi_sync_edge u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (raw_in[gi]),
      .sync (edge_lvl[gi]),
      .rise (edge_rise[gi]),
      .fall (edge_fall[gi])
    );
  end

  logic sck_rise;
  logic sck_fall;
  logic cs_sync;
  logic cs_fall;

  assign sck_rise = edge_rise[0];
  assign sck_fall = edge_fall[0];
  assign cs_sync  = edge_lvl[1];
  assign cs_fall  = edge_fall[1];

  // mosi only needs the level; its two-flop delay matches the sck path, so
  // mosi_sync_reg holds the bit that was on the wire when sck rose.
  logic mosi_meta_reg;
  logic mosi_sync_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mosi_meta_reg <= 1'b0;
      mosi_sync_reg <= 1'b0;
    end else begin
      mosi_meta_reg <= bus.spi_mosi;
      mosi_sync_reg <= mosi_meta_reg;
    end
  end

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  state_t              state_reg,     state_next;
  logic [4:0]          bit_cnt_reg,   bit_cnt_next;
  logic [ADDR_BITS_FLASH-2:0] rx_reg, rx_next;   // received bits so far
  logic [7:0]          tx_reg,        tx_next;   // byte being shifted out
  logic [7:0]          pf_reg,        pf_next;   // prefetched next byte
  logic [ADDR_W-1:0]   mem_addr_reg,  mem_addr_next;
  logic                mem_rd_en_reg, mem_rd_en_next;
  logic                rd_dly_reg,    rd_dly_next;  // mem_rdata valid this cycle
  logic                first_reg,     first_next;   // pending read feeds tx, not pf
  logic                miso_reg,      miso_next;
  logic                oe_reg,        oe_next;
  logic                bad_cmd_reg,   bad_cmd_next;

  // Received bits including the one being sampled this cycle.
  logic [ADDR_BITS_FLASH-1:0] rx_shift;
  assign rx_shift = {rx_reg, mosi_sync_reg};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      bit_cnt_reg   <= '0;
      rx_reg        <= '0;
      tx_reg        <= '0;
      pf_reg        <= '0;
      mem_addr_reg  <= '0;
      mem_rd_en_reg <= 1'b0;
      rd_dly_reg    <= 1'b0;
      first_reg     <= 1'b0;
      miso_reg      <= 1'b0;
      oe_reg        <= 1'b0;
      bad_cmd_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      bit_cnt_reg   <= bit_cnt_next;
      rx_reg        <= rx_next;
      tx_reg        <= tx_next;
      pf_reg        <= pf_next;
      mem_addr_reg  <= mem_addr_next;
      mem_rd_en_reg <= mem_rd_en_next;
      rd_dly_reg    <= rd_dly_next;
      first_reg     <= first_next;
      miso_reg      <= miso_next;
      oe_reg        <= oe_next;
      bad_cmd_reg   <= bad_cmd_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    bit_cnt_next   = bit_cnt_reg;
    rx_next        = rx_reg;
    tx_next        = tx_reg;
    pf_next        = pf_reg;
    mem_addr_next  = mem_addr_reg;
    mem_rd_en_next = 1'b0;
    rd_dly_next    = mem_rd_en_reg;
    first_next     = first_reg;
    miso_next      = miso_reg;
    oe_next        = oe_reg;
    bad_cmd_next   = 1'b0;

    if (cs_sync) begin
      // cs high dominates everything, including an sck edge seen this cycle.
      state_next   = IDLE;
      bit_cnt_next = '0;
      rx_next      = '0;
      miso_next    = 1'b0;
      oe_next      = 1'b0;
      first_next   = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (cs_fall) begin
            state_next   = CMD;
            bit_cnt_next = '0;
            rx_next      = '0;
          end
        end

        CMD: begin
          if (sck_rise) begin
            rx_next = rx_shift[ADDR_BITS_FLASH-2:0];
            if (bit_cnt_reg == 5'd7) begin
              bit_cnt_next = '0;
              if (rx_shift[7:0] == CMD_READ) begin
                state_next = ADDR;
              end else if (rx_shift[7:0] == CMD_RDSR) begin
                state_next = STAT;
                tx_next    = 8'h00;
              end else begin
                state_next   = IGNORE;
                bad_cmd_next = 1'b1;
              end
            end else begin
              bit_cnt_next = bit_cnt_reg + 5'd1;
            end
          end
        end

        ADDR: begin
          if (sck_rise) begin
            rx_next = rx_shift[ADDR_BITS_FLASH-2:0];
            if (bit_cnt_reg == 5'd23) begin
              // Upper address bits alias onto the local memory.
              mem_addr_next  = rx_shift[ADDR_W-1:0];
              mem_rd_en_next = 1'b1;
              first_next     = 1'b1;
              bit_cnt_next   = '0;
              state_next     = DATA;
            end else begin
              bit_cnt_next = bit_cnt_reg + 5'd1;
            end
          end
        end

        DATA: begin
          // Capture returning read data: the initial read goes straight into
          // the shifter, prefetches into the buffer.
          if (rd_dly_reg) begin
            if (first_reg) begin
              tx_next    = bus.mem_rdata;
              first_next = 1'b0;
            end else begin
              pf_next = bus.mem_rdata;
            end
          end
          if (sck_fall) begin
            miso_next = tx_reg[7];
            oe_next   = 1'b1;
            tx_next   = {tx_reg[6:0], 1'b0};
            if (bit_cnt_reg == 5'd0) begin
              // Fetch the following byte while this one is shifting out.
              mem_addr_next  = mem_addr_reg + 1'b1;
              mem_rd_en_next = 1'b1;
            end
            if (bit_cnt_reg == 5'd7) begin
              tx_next      = pf_reg;
              bit_cnt_next = '0;
            end else begin
              bit_cnt_next = bit_cnt_reg + 5'd1;
            end
          end
        end

        STAT: begin
          if (sck_fall) begin
            miso_next = tx_reg[7];
            oe_next   = 1'b1;
            tx_next   = {tx_reg[6:0], 1'b0};
          end
        end

        IGNORE: begin
          miso_next = 1'b0;
          oe_next   = 1'b0;
        end

        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.spi_miso    = miso_reg;
  assign bus.spi_miso_oe = oe_reg;
  assign bus.mem_rd_en   = mem_rd_en_reg;
  assign bus.mem_addr    = mem_addr_reg;
  assign busy            = (state_reg != IDLE);
  assign bad_cmd         = bad_cmd_reg;

  // Deliberately unused: sck level, cs rise, top received bit.
  logic unused_ok;
  assign unused_ok = &{1'b0, edge_lvl[0], edge_rise[1], rx_shift[ADDR_BITS_FLASH-1]};

endmodule

// File: tb/tb_spi_flash_responder.sv
// ----------------------------------------------------------------------------
// tb_spi_flash_responder
// Drives SPI transactions into spi_flash_responder, serves its memory port
// from a local array, and checks returned bytes, output enables, busy,
// bad_cmd and memory read addresses.
// ----------------------------------------------------------------------------
module tb_spi_flash_responder;
  import spi_flash_pkg::*;

  localparam int AW   = 12;
  localparam int HALF = 5;   // sck half period in clk cycles (clk/10)

  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  logic bad_cmd;

  always #5 clk = ~clk;

  spi_flash_responder_if #(.ADDR_W(AW)) bus ();

  spi_flash_responder #(.ADDR_W(AW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus.slave),
    .busy   (busy),
    .bad_cmd(bad_cmd)
  );

  // Memory behind the responder: registered read.
  logic [7:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];
  end

  // Monitors of strobes.
  logic [AW-1:0] rd_q [$];
  int bad_cnt = 0;
  always @(negedge clk) begin
    if (bus.mem_rd_en === 1'b1) rd_q.push_back(bus.mem_addr);
    if (bad_cmd === 1'b1) bad_cnt++;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pulse_at(input int idx);
    if (idx < rd_q.size()) return 32'(rd_q[idx]);
    return 32'hFFFF_FFFF;
  endfunction

  // Results of the last spi_bits call.
  logic [7:0] b_rx;
  logic b_oe_any, b_oe_all, b_busy_all, b_busy_any;

  task automatic spi_bits(input logic [7:0] tx, input int nbits);
    b_rx = '0; b_oe_any = 1'b0; b_oe_all = 1'b1; b_busy_all = 1'b1; b_busy_any = 1'b0;
    for (int i = 7; i > 7 - nbits; i--) begin
      bus.spi_mosi = tx[i];
      repeat (HALF) @(negedge clk);
      b_rx[i]    = bus.spi_miso;
      b_oe_any   = b_oe_any | bus.spi_miso_oe;
      b_oe_all   = b_oe_all & bus.spi_miso_oe;
      b_busy_all = b_busy_all & busy;
      b_busy_any = b_busy_any | busy;
      bus.spi_sck = 1'b1;
      repeat (HALF) @(negedge clk);
      bus.spi_sck = 1'b0;
    end
  endtask

  // Results of the last run_txn call.
  logic [7:0] rx_bytes [8];
  logic hdr_oe_any, data_oe_any, data_oe_all, txn_busy_all, end_busy, end_oe;
  int pulses_b0, txn_pulses, bad_delta, txn_base;

  task automatic run_txn(input logic [7:0] op, input logic [23:0] addr,
                         input logic send_addr, input int nbytes);
    int bb;
    txn_base = rd_q.size();
    bb = bad_cnt;
    pulses_b0 = 0;
    bus.spi_cs = 1'b0;
    repeat (HALF) @(negedge clk);
    spi_bits(op, 8);
    hdr_oe_any = b_oe_any;
    txn_busy_all = b_busy_all;
    if (send_addr) begin
      for (int k = 2; k >= 0; k--) begin
        spi_bits(addr[8*k +: 8], 8);
        hdr_oe_any = hdr_oe_any | b_oe_any;
        txn_busy_all = txn_busy_all & b_busy_all;
      end
    end
    data_oe_any = 1'b0;
    data_oe_all = 1'b1;
    for (int k = 0; k < nbytes; k++) begin
      spi_bits(8'h00, 8);
      rx_bytes[k] = b_rx;
      data_oe_any = data_oe_any | b_oe_any;
      data_oe_all = data_oe_all & b_oe_all;
      txn_busy_all = txn_busy_all & b_busy_all;
      if (k == 0) pulses_b0 = rd_q.size() - txn_base;
    end
    repeat (HALF) @(negedge clk);
    bus.spi_cs = 1'b1;
    repeat (3) @(negedge clk);
    end_busy = busy;
    end_oe = bus.spi_miso_oe;
    repeat (HALF) @(negedge clk);
    txn_pulses = rd_q.size() - txn_base;
    bad_delta = bad_cnt - bb;
  endtask

  typedef struct {
    logic [7:0]    op;
    logic [23:0]   addr;
    logic          send_addr;
    logic [7:0]    exp0;
    logic [7:0]    exp1;
    logic          exp_oe;
    int            exp_bad;
    int            exp_pb0;
    logic [AW-1:0] exp_a0;
    logic [AW-1:0] exp_a1;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bus.spi_cs = 1'b1; bus.spi_sck = 1'b0; bus.spi_mosi = 1'b0;
    rst_n = 1'b0;

    for (int i = 0; i < (1<<AW); i++) mem[i] = 8'($urandom);
    mem[12'h010] = 8'hA5; mem[12'h011] = 8'h3C; mem[12'h012] = 8'hC3;
    mem[12'hFFF] = 8'h11; mem[12'h000] = 8'h22;
    mem[12'h004] = 8'h5A; mem[12'h005] = 8'h96;

    vecs[0] = '{8'h03, 24'h000010, 1'b1, 8'hA5, 8'h3C, 1'b1, 0, 2, 12'h010, 12'h011};
    vecs[1] = '{8'h03, 24'h000FFF, 1'b1, 8'h11, 8'h22, 1'b1, 0, 2, 12'hFFF, 12'h000};
    vecs[2] = '{8'h03, 24'hABCFFF, 1'b1, 8'h11, 8'h22, 1'b1, 0, 2, 12'hFFF, 12'h000};
    vecs[3] = '{8'h05, 24'h000000, 1'b0, 8'h00, 8'h00, 1'b1, 0, 0, 12'h000, 12'h000};
    vecs[4] = '{8'h9F, 24'h000010, 1'b1, 8'h00, 8'h00, 1'b0, 1, 0, 12'h000, 12'h000};
    vecs[5] = '{8'h03, 24'h000011, 1'b1, 8'h3C, 8'hC3, 1'b1, 0, 2, 12'h011, 12'h012};
    vecs[6] = '{8'h07, 24'h000004, 1'b1, 8'h00, 8'h00, 1'b0, 1, 0, 12'h000, 12'h000};
    vecs[7] = '{8'h03, 24'hF00004, 1'b1, 8'h5A, 8'h96, 1'b1, 0, 2, 12'h004, 12'h005};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_spi_outs", {31'd0, bus.spi_miso} | {31'd0, bus.spi_miso_oe}, 0);
    check("reset_mem_outs", {19'd0, bus.mem_rd_en, bus.mem_addr}, 0);
    check("reset_flags", {30'd0, busy, bad_cmd}, 0);
    rst_n = 1'b1;
    repeat (2 * HALF) @(negedge clk);

    // Table-driven transactions
    for (int v = 0; v < 8; v++) begin
      run_txn(vecs[v].op, vecs[v].addr, vecs[v].send_addr, 2);
      $display("vec %0d: op=%02h addr=%06h rx=%02h %02h pulses=%0d bad=%0d",
               v, vecs[v].op, vecs[v].addr, rx_bytes[0], rx_bytes[1], txn_pulses, bad_delta);
      check($sformatf("vec%0d_byte0", v), 32'(rx_bytes[0]), 32'(vecs[v].exp0));
      check($sformatf("vec%0d_byte1", v), 32'(rx_bytes[1]), 32'(vecs[v].exp1));
      check($sformatf("vec%0d_hdr_oe", v), 32'(hdr_oe_any), 0);
      if (vecs[v].exp_oe) check($sformatf("vec%0d_data_oe_all", v), 32'(data_oe_all), 1);
      else                check($sformatf("vec%0d_data_oe_any", v), 32'(data_oe_any), 0);
      check($sformatf("vec%0d_bad_cmd", v), bad_delta, vecs[v].exp_bad);
      check($sformatf("vec%0d_pulses_byte0", v), pulses_b0, vecs[v].exp_pb0);
      if (vecs[v].exp_pb0 != 0) begin
        check($sformatf("vec%0d_rd_addr0", v), pulse_at(txn_base), 32'(vecs[v].exp_a0));
        check($sformatf("vec%0d_rd_addr1", v), pulse_at(txn_base + 1), 32'(vecs[v].exp_a1));
      end else begin
        check($sformatf("vec%0d_no_reads", v), txn_pulses, 0);
      end
      check($sformatf("vec%0d_busy_during", v), 32'(txn_busy_all), 1);
      check($sformatf("vec%0d_busy_after_cs", v), 32'(end_busy), 0);
      check($sformatf("vec%0d_oe_after_cs", v), 32'(end_oe), 0);
    end

    // Abort after 12 address bits; cs rise coincides with the last sck fall.
    base = rd_q.size();
    bus.spi_cs = 1'b0;
    repeat (HALF) @(negedge clk);
    spi_bits(8'h03, 8);
    spi_bits(8'h00, 8);
    spi_bits(8'h00, 4);
    bus.spi_cs = 1'b1;
    repeat (3) @(negedge clk);
    $display("abort: busy=%0b oe=%0b reads=%0d", busy, bus.spi_miso_oe, rd_q.size() - base);
    check("abort_busy", 32'(busy), 0);
    check("abort_oe", 32'(bus.spi_miso_oe), 0);
    check("abort_no_reads", rd_q.size() - base, 0);
    repeat (HALF) @(negedge clk);
    run_txn(8'h03, 24'h000004, 1'b1, 1);
    $display("after abort read: rx=%02h", rx_bytes[0]);
    check("abort_next_read", 32'(rx_bytes[0]), 32'h5A);

    // Reset in the middle of data byte 1
    bus.spi_cs = 1'b0;
    repeat (HALF) @(negedge clk);
    spi_bits(8'h03, 8);
    spi_bits(8'h00, 8);
    spi_bits(8'h00, 8);
    spi_bits(8'h10, 8);
    spi_bits(8'h00, 8);
    check("rst_pre_byte0", 32'(b_rx), 32'hA5);
    spi_bits(8'h00, 4);
    repeat (HALF) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    $display("reset mid-data: miso=%0b oe=%0b addr=%03h busy=%0b", bus.spi_miso,
             bus.spi_miso_oe, bus.mem_addr, busy);
    check("rst_spi_outs", {30'd0, bus.spi_miso, bus.spi_miso_oe}, 0);
    check("rst_mem_outs", {19'd0, bus.mem_rd_en, bus.mem_addr}, 0);
    check("rst_flags", {30'd0, busy, bad_cmd}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    base = rd_q.size();
    spi_bits(8'h00, 8);
    check("rst_no_resume_oe", 32'(b_oe_any), 0);
    check("rst_no_resume_busy", 32'(b_busy_any), 0);
    check("rst_no_resume_reads", rd_q.size() - base, 0);
    bus.spi_cs = 1'b1;
    repeat (2 * HALF) @(negedge clk);
    run_txn(8'h03, 24'h000011, 1'b1, 1);
    $display("after reset read: rx=%02h", rx_bytes[0]);
    check("rst_next_read", 32'(rx_bytes[0]), 32'h3C);

    // Randomized reads against an address-arithmetic reference model.
    for (int t = 0; t < 20; t++) begin
      logic [23:0] a24;
      int n, ba, exp_a;
      a24 = 24'($urandom);
      n = int'($urandom_range(1, 4));
      ba = int'(a24) % (1 << AW);
      run_txn(8'h03, a24, 1'b1, n);
      $display("rand %0d: addr=%06h nbytes=%0d reads=%0d", t, a24, n, txn_pulses);
      for (int k = 0; k < n; k++) begin
        exp_a = (ba + k) % (1 << AW);
        check($sformatf("rand%0d_byte%0d", t, k), 32'(rx_bytes[k]), 32'(mem[exp_a]));
      end
      // One initial read, then one prefetch per fall that starts a byte.
      check($sformatf("rand%0d_read_count", t), txn_pulses, n + 2);
      for (int j = 0; j < n + 2; j++) begin
        exp_a = (ba + j) % (1 << AW);
        check($sformatf("rand%0d_rd_addr%0d", t, j), pulse_at(txn_base + j), 32'(exp_a));
      end
      check($sformatf("rand%0d_oe", t), 32'(data_oe_all), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
